// File: rtl/conv_input_interface_if.sv
// Controller/memory-facing bundle of the conv input interface.
// slave is the block itself; master is the controller plus image memory.
interface conv_input_interface_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int ADDR_WIDTH  = 6
);
  logic [1:0]                                      input_interface_cmd;
  logic [1:0]                                      input_interface_ack;
  logic                                            mem_rd_en;
  logic [ADDR_WIDTH-1:0]                           mem_addr;
  logic [DATA_WIDTH-1:0]                           mem_rd_data;
  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]   window_out;
  logic                                            busy;

  modport slave (
    input  input_interface_cmd, mem_rd_data,
    output input_interface_ack, mem_rd_en, mem_addr, window_out, busy
  );

  modport master (
    output input_interface_cmd, mem_rd_data,
    input  input_interface_ack, mem_rd_en, mem_addr, window_out, busy
  );
endinterface

// File: rtl/conv_input_interface.sv
// K-row line buffer fed from image memory; serves KxK windows to the conv layer
// on SHIFT, refills rows on PRELOAD / LOAD.
module conv_input_interface #(
  parameter int DATA_WIDTH  = 8,
  parameter int IMG_WIDTH   = 8,
  parameter int IMG_HEIGHT  = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int ADDR_WIDTH  = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  conv_input_interface_if.slave   bus
);
  localparam int K   = KERNEL_SIZE;
  localparam int W   = IMG_WIDTH;
  localparam int H   = IMG_HEIGHT;
  localparam int CPW = (W > 1) ? $clog2(W) : 1;
  localparam int RW  = (K > 1) ? $clog2(K) : 1;
  localparam int NRW = $clog2(H + 1);
  localparam int CNW = $clog2(K * W + 1);

  localparam logic [1:0] CMD_PRELOAD = 2'd1, CMD_SHIFT = 2'd2, CMD_LOAD = 2'd3;
  localparam logic [1:0] ACK_IDLE = 2'd0, ACK_PRELOAD_FIN = 2'd1,
                         ACK_SHIFT_FIN = 2'd2, ACK_LOAD_FIN = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_PRELOAD_RD, S_LOAD_RD, S_SHIFT} state_e;

  state_e                              state_q, state_d;
  logic [K-1:0][W-1:0][DATA_WIDTH-1:0] lb_q;
  logic [K*K-1:0][DATA_WIDTH-1:0]      win_q;
  logic [CPW-1:0]                      col_ptr_q, wr_col_q;
  logic [RW-1:0]                       wr_row_q;
  logic [NRW-1:0]                      next_row_q;
  logic [CNW-1:0]                      iss_left_q;
  logic                                iss_q, pend_q, zfill_q, rd_en_q;
  logic [ADDR_WIDTH-1:0]               addr_q;
  logic [1:0]                          ack_q;
  logic                                last_wr;
  logic [DATA_WIDTH-1:0]               wr_data;

  assign bus.input_interface_ack = ack_q;
  assign bus.mem_rd_en           = rd_en_q;
  assign bus.mem_addr            = addr_q;
  assign bus.window_out          = win_q;
  assign bus.busy                = (state_q != S_IDLE);

  // Both fill commands finish on the last column of the bottom row.
  assign last_wr = pend_q && (wr_row_q == RW'(K - 1)) && (wr_col_q == CPW'(W - 1));
  assign wr_data = zfill_q ? '0 : bus.mem_rd_data;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        case (bus.input_interface_cmd)
          CMD_PRELOAD: state_d = S_PRELOAD_RD;
          CMD_SHIFT:   state_d = S_SHIFT;
          CMD_LOAD:    state_d = S_LOAD_RD;
          default:     state_d = S_IDLE;
        endcase
      end
      // Stay busy through the ack cycle so a command there is ignored.
      S_PRELOAD_RD, S_LOAD_RD: if (ack_q != ACK_IDLE) state_d = S_IDLE;
      S_SHIFT:                 state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb_q       <= '0;
      win_q      <= '0;
      col_ptr_q  <= '0;
      wr_col_q   <= '0;
      wr_row_q   <= '0;
      next_row_q <= '0;
      iss_left_q <= '0;
      iss_q      <= 1'b0;
      pend_q     <= 1'b0;
      zfill_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      ack_q      <= ACK_IDLE;
    end else begin
      ack_q  <= ACK_IDLE;
      pend_q <= iss_q;

      // Issue side: iss_q paces the fill even when a zero row suppresses reads.
      if (iss_q) begin
        iss_left_q <= iss_left_q - CNW'(1);
        if (iss_left_q == CNW'(1)) begin
          iss_q   <= 1'b0;
          rd_en_q <= 1'b0;
        end else if (rd_en_q) begin
          addr_q <= addr_q + ADDR_WIDTH'(1);
        end
      end

      // Write side: data lands one cycle after its strobe.
      if (pend_q) begin
        lb_q[wr_row_q][wr_col_q] <= wr_data;
        if (last_wr) begin
          ack_q <= (state_q == S_PRELOAD_RD) ? ACK_PRELOAD_FIN : ACK_LOAD_FIN;
        end else if (wr_col_q == CPW'(W - 1)) begin
          wr_col_q <= '0;
          wr_row_q <= wr_row_q + RW'(1);
        end else begin
          wr_col_q <= wr_col_q + CPW'(1);
        end
      end

      if (state_q == S_IDLE) begin
        case (bus.input_interface_cmd)
          CMD_PRELOAD: begin
            iss_q      <= 1'b1;
            rd_en_q    <= 1'b1;
            zfill_q    <= 1'b0;
            iss_left_q <= CNW'(K * W);
            addr_q     <= '0;
            wr_row_q   <= '0;
            wr_col_q   <= '0;
            col_ptr_q  <= '0;
            next_row_q <= NRW'(K);
          end
          CMD_LOAD: begin
            for (int r = 0; r < K - 1; r++) lb_q[r] <= lb_q[r+1];
            iss_q      <= 1'b1;
            iss_left_q <= CNW'(W);
            wr_row_q   <= RW'(K - 1);
            wr_col_q   <= '0;
            col_ptr_q  <= '0;
            if (next_row_q == NRW'(H)) begin
              zfill_q <= 1'b1;
              rd_en_q <= 1'b0;
            end else begin
              zfill_q    <= 1'b0;
              rd_en_q    <= 1'b1;
              addr_q     <= ADDR_WIDTH'(next_row_q) * ADDR_WIDTH'(W);
              next_row_q <= next_row_q + NRW'(1);
            end
          end
          CMD_SHIFT: begin
            for (int r = 0; r < K; r++)
              for (int c = 0; c < K; c++)
                win_q[r*K+c] <= lb_q[r][col_ptr_q + CPW'(c)];
            ack_q     <= ACK_SHIFT_FIN;
            col_ptr_q <= (col_ptr_q == CPW'(W - K)) ? '0 : col_ptr_q + CPW'(1);
          end
          default: ;
        endcase
      end
    end
  end
endmodule
